// File: rtl/alu_exec_unit_pkg.sv
// alu_ctrl_pkg: ALU control codes, execute-stage FSM states and NZCV flag bit positions.
package alu_ctrl_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0111,
        ALU_XOR = 4'b1001,
        ALU_MUL = 4'b1111
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} exec_state_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: valid/ready operation request and result/flags response bundle.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             illegal;
    modport master (
        output in_valid, alu_ctrl, op_a, op_b, set_flags, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );
    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, set_flags, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, done pulses after WIDTH cycles.
module alu_mul_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] mcand, mplier;
    logic [CW-1:0]    cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= cnt == CW'(1);
            if (start) begin
                p      <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= CW'(WIDTH);
            end else if (cnt != '0) begin
                p      <= mplier[0] ? p + mcand : p;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
        end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with valid/ready ops, NZCV flag register and iterative MUL.
module alu_exec_unit import alu_ctrl_pkg::*; #(parameter int WIDTH = 32) (
    input logic           clk,
    input logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam int M = WIDTH - 1;
    exec_state_e      state;
    logic [WIDTH-1:0] a, b, res, res_q, mul_p;
    logic [WIDTH:0]   sum;
    logic [3:0]       code, flg, nf;
    logic             is_add, is_sub, is_and, is_xor, is_mul, legal;
    logic             c_n, v_n, in_rdy, accept, ill, sf_q, mul_done;
    assign a      = bus.op_a;
    assign b      = bus.op_b;
    assign code   = bus.alu_ctrl;
    assign is_add = code == ALU_ADD;
    assign is_sub = code == ALU_SUB;
    assign is_and = code == ALU_AND;
    assign is_xor = code == ALU_XOR;
    assign is_mul = code == ALU_MUL;
    assign legal  = is_add | is_sub | is_and | is_xor;
    assign sum    = {1'b0, a} + {1'b0, b};
    assign res    = is_add ? sum[M:0] : is_sub ? a - b : is_and ? a & b : is_xor ? a ^ b : '0;
    // SUB carry is ARM-style no-borrow; logic ops keep C and V.
    assign c_n    = is_add ? sum[WIDTH] : is_sub ? a >= b : flg[FLAG_C];
    assign v_n    = is_add ? (a[M] == b[M]) && (res[M] != a[M]) :
                    is_sub ? (a[M] != b[M]) && (res[M] != a[M]) : flg[FLAG_V];
    assign nf     = {res[M], res == '0, c_n, v_n};
    assign in_rdy = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept = bus.in_valid && in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = state == DONE;
    assign bus.result    = res_q;
    assign bus.flags     = flg;
    assign bus.illegal   = ill;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .p     (mul_p)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            res_q <= '0;
            flg   <= '0;
            ill   <= 1'b0;
            sf_q  <= 1'b0;
        end else if (accept) begin
            state <= is_mul ? BUSY : DONE;
            res_q <= is_mul ? res_q : res;
            ill   <= !legal && !is_mul;
            sf_q  <= bus.set_flags;
            if (bus.set_flags && legal) flg <= nf;
        end else if (state == BUSY && mul_done) begin
            state <= DONE;
            res_q <= mul_p;
            if (sf_q) begin
                flg[FLAG_N] <= mul_p[M];
                flg[FLAG_Z] <= mul_p == '0;
            end
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized scoreboard bench with directed latency, backpressure and reset cases.
module tb_alu_exec_unit;
    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
        logic        ill;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp_rand = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [3:0] mflags = 4'h0;
    exp_t sb[$];
    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic sf);
        exp_t e;
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        longint s;
        logic [63:0] u;
        logic cc = mflags[1];
        logic v = mflags[0];
        e.ill = 1'b0;
        case (c)
            4'b0000: begin u = 64'(a) + 64'(b); e.r = u[31:0]; cc = u[32]; s = sa + sb_; v = s != longint'(int'(s)); end
            4'b0001: begin e.r = a - b; cc = a >= b; s = sa - sb_; v = s != longint'(int'(s)); end
            4'b0111: e.r = a & b;
            4'b1001: e.r = a ^ b;
            4'b1111: begin u = 64'(a) * 64'(b); e.r = u[31:0]; end
            default: begin e.r = 32'h0; e.ill = 1'b1; end
        endcase
        if (sf && !e.ill) mflags = {e.r[31], e.r == 32'h0, cc, v};
        e.f = mflags;
        return e;
    endfunction
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic sf, output int waits);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.op_a = a;
        bus.op_b = b;
        bus.set_flags = sf;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for code %b", c);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back(model(c, a, b, sf));
        #1 bus.in_valid = 1'b0;
    endtask
    function automatic logic [31:0] rnd_op();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
    endfunction
    function automatic logic [3:0] rnd_code();
        int r = $urandom_range(0, 9);
        logic [3:0] c;
        if (r < 3) return 4'b0000;
        if (r < 5) return 4'b0001;
        if (r == 5) return 4'b0111;
        if (r == 6) return 4'b1001;
        if (r == 7) return 4'b1111;
        do c = 4'($urandom_range(0, 15)); while (c inside {4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1111});
        return c;
    endfunction
    always @(posedge clk) begin
        #1;
        if (bp_rand) bus.out_ready = $urandom_range(0, 3) != 0;
    end
    // Compare every cycle a result is presented; pop only on the completing handshake.
    always @(negedge clk)
        if (!rst && bus.out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result %0h flags %b illegal %b with empty queue", bus.result, bus.flags, bus.illegal);
            end else begin
                if ({bus.result, bus.flags, bus.illegal} !== sb[0]) begin
                    errors++;
                    $display("FAIL sb_compare: got r=%0h f=%b ill=%b expected r=%0h f=%b ill=%b",
                             bus.result, bus.flags, bus.illegal, sb[0].r, sb[0].f, sb[0].ill);
                end
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    initial begin
        int w, lat, n;
        logic [31:0] r0;
        logic [3:0] f0;
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'h0;
        bus.op_a = 32'h0;
        bus.op_b = 32'h0;
        bus.set_flags = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("reset_out_valid", 64'(bus.out_valid), 0);
        chk("reset_result", 64'(bus.result), 0);
        chk("reset_flags", 64'(bus.flags), 0);
        chk("reset_illegal", 64'(bus.illegal), 0);
        chk("reset_in_ready", 64'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(4'b0000, 32'd5, 32'd3, 1'b1, w);
        @(negedge clk);
        chk("add_latency_1", 64'(bus.out_valid), 1);
        @(posedge clk); #1;
        issue(4'b0001, 32'd3, 32'd5, 1'b1, w);
        issue(4'b0001, 32'd5, 32'd5, 1'b1, w);
        issue(4'b0000, 32'h7fffffff, 32'd1, 1'b1, w);
        issue(4'b0000, 32'hffffffff, 32'd1, 1'b0, w);
        issue(4'b1111, 32'd6, 32'd7, 1'b1, w);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            chk("mul_busy_in_ready", 64'(bus.in_ready), 0);
        end
        chk("mul_latency", 64'(lat), 33);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(4'b0000, 32'd10, 32'd20, 1'b1, w);
        @(negedge clk);
        chk("bp_out_valid", 64'(bus.out_valid), 1);
        r0 = bus.result;
        f0 = bus.flags;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_result_stable", 64'(bus.result), 64'(r0));
            chk("bp_flags_stable", 64'(bus.flags), 64'(f0));
            chk("bp_in_ready", 64'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(4'b1001, 32'hf0f0f0f0, 32'hff00ff00, 1'b1, w);
        chk("bp_same_cycle_accept", 64'(w), 0);
        issue(4'b0011, 32'd9, 32'd9, 1'b1, w);
        bp_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) @(posedge clk);
            if (n != 0) #1;
            issue(rnd_code(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), w);
        end
        bp_rand = 1'b0;
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        issue(4'b0000, 32'h7fffffff, 32'd1, 1'b1, w);
        issue(4'b1111, 32'd123, 32'd456, 1'b1, w);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        sb.delete();
        mflags = 4'h0;
        #1;
        chk("rst_mul_out_valid", 64'(bus.out_valid), 0);
        chk("rst_mul_result", 64'(bus.result), 0);
        chk("rst_mul_flags", 64'(bus.flags), 0);
        chk("rst_mul_illegal", 64'(bus.illegal), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 1);
        chk("post_rst_out_valid", 64'(bus.out_valid), 0);
        @(posedge clk); #1;
        issue(4'b0000, 32'd5, 32'd3, 1'b1, w);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
